// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } state_e;

    typedef enum logic {
        CMD_RD,
        CMD_WR
    } cmd_e;

    localparam int SECTOR_BYTES = 512;
    localparam int PTR_W        = 2;

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester
// found after the pointer index, wrapping around.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o
);

    // Scan from farthest to nearest so the nearest request overwrites the rest.
    always_comb begin
        grant_o = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD host sector port between NREQ drive units, round-robin.
// Define SD_ARB_TIMEOUT_EN to add an ack timeout in ISSUE with a req_err pulse.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NREQ           = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NREQ*32-1:0]                req_lba,
    input  logic [NREQ-1:0]                   req_rd,
    input  logic [NREQ-1:0]                   req_wr,
    output logic [NREQ-1:0]                   req_ack,
    output logic [NREQ-1:0]                   req_err,
    input  logic [NREQ*8-1:0]                 req_buff_din,
    output logic [NREQ-1:0]                   req_buff_wr,
    output logic [$clog2(SECTOR_BYTES)-1:0]   req_buff_addr,
    output logic [7:0]                        req_buff_dout,
    output logic [NREQ-1:0]                   grant,
    output logic [31:0]                       sd_lba,
    output logic                              sd_rd,
    output logic                              sd_wr,
    input  logic                              sd_ack,
    input  logic [$clog2(SECTOR_BYTES)-1:0]   sd_buff_addr,
    input  logic [7:0]                        sd_buff_dout,
    output logic [7:0]                        sd_buff_din,
    input  logic                              sd_buff_wr
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [31:0]       lba_q, lba_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [2:0]        sync_q;
    logic              ack_s, ack_rise, ack_fall;
    logic [NREQ-1:0]   pick;
    logic [31:0]       lba_sel;
    logic              rd_sel;
    cmd_e              cmd_sel;
    logic [PTR_W-1:0]  owner_idx;
    logic              timeout;

    // sync_q[1] is the synchronised ack; sync_q[2] is its previous value.
    assign ack_s    = sync_q[1];
    assign ack_rise = sync_q[1] & ~sync_q[2];
    assign ack_fall = ~sync_q[1] & sync_q[2];

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req_i   (req_rd | req_wr),
        .ptr_i   (ptr_q),
        .grant_o (pick)
    );

    always_comb begin
        lba_sel   = '0;
        rd_sel    = 1'b0;
        owner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                lba_sel = req_lba[i*32 +: 32];
                rd_sel  = req_rd[i];
            end
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
        cmd_sel = rd_sel ? CMD_RD : CMD_WR;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: if (|(req_rd | req_wr)) begin
                grant_d = pick;
                lba_d   = lba_sel;
                rd_d    = (cmd_sel == CMD_RD);
                wr_d    = (cmd_sel == CMD_WR);
                state_d = ISSUE;
            end
            ISSUE: if (ack_rise) begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = XFER;
            end else if (timeout) begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = DONE;
            end
            XFER: if (ack_fall) state_d = DONE;
            DONE: begin
                grant_d = '0;
                ptr_d   = owner_idx;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ptr_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
            sync_q  <= {sync_q[1:0], sd_ack};
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]     to_cnt_q;
    logic [NREQ-1:0] err_q;

    assign timeout = (state_q == ISSUE) && (to_cnt_q == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk) begin
        if (reset || state_q != ISSUE) to_cnt_q <= '0;
        else                           to_cnt_q <= to_cnt_q + 24'd1;
        if (reset)                     err_q <= '0;
        else if (timeout && !ack_rise) err_q <= grant_q;
        else                           err_q <= '0;
    end

    assign req_err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign req_err = '0;
`endif

    // Host read data fans out to all; the write strobe and acks only to the owner.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_route
            assign req_ack[gi]     = ack_s & grant_q[gi];
            assign req_buff_wr[gi] = sd_ack & sd_buff_wr & grant_q[gi];
        end
    endgenerate

    always_comb begin
        sd_buff_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) sd_buff_din = req_buff_din[i*8 +: 8];
        end
    end

    assign req_buff_addr = sd_buff_addr;
    assign req_buff_dout = sd_buff_dout;
    assign grant         = grant_q;
    assign sd_lba        = lba_q;
    assign sd_rd         = rd_q;
    assign sd_wr         = wr_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: stimulus queues expected grants,
// a negedge monitor checks each grant and its byte/error counts.
module tb_sd_sector_arbiter;

    localparam int NREQ = 2;

    logic              clk;
    logic              reset;
    logic [NREQ*32-1:0] req_lba;
    logic [NREQ-1:0]   req_rd, req_wr;
    logic [NREQ-1:0]   req_ack, req_err;
    logic [NREQ*8-1:0] req_buff_din;
    logic [NREQ-1:0]   req_buff_wr;
    logic [8:0]        req_buff_addr;
    logic [7:0]        req_buff_dout;
    logic [NREQ-1:0]   grant;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;
    logic              sd_buff_wr;

    sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_lba       (req_lba),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_ack       (req_ack),
        .req_err       (req_err),
        .req_buff_din  (req_buff_din),
        .req_buff_wr   (req_buff_wr),
        .req_buff_addr (req_buff_addr),
        .req_buff_dout (req_buff_dout),
        .grant         (grant),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_din   (sd_buff_din),
        .sd_buff_wr    (sd_buff_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic [31:0]     lba;
        logic            rd;
        logic            wr;
        int              nbytes;
        int              nerr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   stray    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [NREQ-1:0] g, input logic [31:0] lba,
                            input logic rd, input logic wr, input int nb, input int ne);
        exp_t e;
        e.grant = g; e.lba = lba; e.rd = rd; e.wr = wr; e.nbytes = nb; e.nerr = ne;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: grant rising pops an expectation, grant falling closes it.
    logic [NREQ-1:0] prev_grant = '0;
    exp_t cur;
    int   cnt_wr = 0;
    int   cnt_err = 0;

    always @(negedge clk) begin
        if (grant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant actual=%0h required=none", grant);
            end else begin
                cur = exp_q.pop_front();
                chk("grant", 64'(grant), 64'(cur.grant));
                chk("sd_lba", 64'(sd_lba), 64'(cur.lba));
                chk("sd_rd", 64'(sd_rd), 64'(cur.rd));
                chk("sd_wr", 64'(sd_wr), 64'(cur.wr));
            end
            cnt_wr  = 0;
            cnt_err = 0;
        end
        if (grant != '0) begin
            if (|(req_buff_wr & grant)) cnt_wr++;
            if (|(req_err & grant))     cnt_err++;
        end
        if (|(req_buff_wr & ~grant) || |(req_ack & ~grant) || |(req_err & ~grant))
            stray++;
        if (grant == '0 && prev_grant != '0) begin
            chk("nbytes", 64'(cnt_wr), 64'(cur.nbytes));
            chk("nerr", 64'(cnt_err), 64'(cur.nerr));
        end
        prev_grant = grant;
    end

    // Host + requester model for one sector transfer.
    task automatic serve(input int owner, input int nbytes, input bit abort, input logic [7:0] din_exp);
        int n;
        bit was_rd;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[owner] = 1'b1;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 100) begin tick; n++; end
        chk("cmd_seen", 64'(sd_rd | sd_wr), 64'd1);
        was_rd = sd_rd;
        repeat (2) tick;
        sd_ack = 1'b1;
        n = 0;
        while ((sd_rd || sd_wr) && n < 20) begin tick; n++; end
        chk("cmd_clear", 64'(sd_rd | sd_wr), 64'd0);
        chk("req_ack", 64'(req_ack), 64'(oh));
        if (was_rd) req_rd[owner] = 1'b0;
        else        req_wr[owner] = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            sd_buff_addr = 9'(b);
            sd_buff_dout = 8'(b);
            sd_buff_wr   = 1'b1;
            if (b == 0) chk("sd_buff_din", 64'(sd_buff_din), 64'(din_exp));
            if (b == nbytes - 1) chk("buff_addr", 64'(req_buff_addr), 64'(b));
            if (abort && b == nbytes - 1) reset = 1'b1;
            tick;
        end
        if (abort) return;
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        n = 0;
        while (grant != '0 && n < 20) begin tick; n++; end
        chk("grant_release", 64'(grant), 64'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        req_lba = '0; req_rd = '0; req_wr = '0;
        req_buff_din = {8'hA5, 8'h3C};
        sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_sd_rd", 64'(sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(sd_wr), 64'd0);
        chk("rst_sd_lba", 64'(sd_lba), 64'd0);
        chk("rst_req_err", 64'(req_err), 64'd0);
        chk("rst_sd_buff_din", 64'(sd_buff_din), 64'd0);

        // Single read, 512 bytes; later LBA change must not reach sd_lba.
        req_lba[31:0] = 32'h1A2;
        push_exp(2'b01, 32'h1A2, 1'b1, 1'b0, 512, 0);
        req_rd[0] = 1'b1;
        n = 0;
        while (!sd_rd && n < 20) begin tick; n++; end
        req_lba[31:0] = 32'hDEADBEEF;
        tick;
        chk("lba_hold", 64'(sd_lba), 64'h1A2);
        serve(0, 512, 1'b0, 8'h3C);
        $display("txn1 read req0 done");

        // Simultaneous requests with pointer 0: 1 then 0, then 1 again.
        req_lba = {32'h20, 32'h10};
        push_exp(2'b10, 32'h20, 1'b1, 1'b0, 8, 0);
        push_exp(2'b01, 32'h10, 1'b1, 1'b0, 8, 0);
        req_rd = 2'b11;
        serve(1, 8, 1'b0, 8'hA5);
        serve(0, 8, 1'b0, 8'h3C);
        req_lba[63:32] = 32'h30;
        push_exp(2'b10, 32'h30, 1'b1, 1'b0, 8, 0);
        req_rd[1] = 1'b1;
        serve(1, 8, 1'b0, 8'hA5);
        $display("txn2 round-robin sequence done");

        // rd and wr together: rd first, wr stays pending and is granted next.
        req_lba[63:32] = 32'h55;
        push_exp(2'b10, 32'h55, 1'b1, 1'b0, 4, 0);
        push_exp(2'b10, 32'h55, 1'b0, 1'b1, 4, 0);
        req_rd[1] = 1'b1;
        req_wr[1] = 1'b1;
        serve(1, 4, 1'b0, 8'hA5);
        serve(1, 4, 1'b0, 8'hA5);
        $display("txn3 rd+wr req1 done");

        // Reset during the transfer at byte 100.
        req_lba[31:0] = 32'h77;
        push_exp(2'b01, 32'h77, 1'b1, 1'b0, 100, 0);
        req_rd[0] = 1'b1;
        serve(0, 100, 1'b1, 8'h3C);
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_sd_rd", 64'(sd_rd), 64'd0);
        chk("abort_sd_wr", 64'(sd_wr), 64'd0);
        chk("abort_sd_lba", 64'(sd_lba), 64'd0);
        chk("abort_req_ack", 64'(req_ack), 64'd0);
        chk("abort_buff_wr", 64'(req_buff_wr), 64'd0);
        chk("abort_buff_din", 64'(sd_buff_din), 64'd0);
        repeat (2) tick;
        reset = 1'b0;
        repeat (4) tick;
        chk("late_ack_grant", 64'(grant), 64'd0);
        chk("late_ack_buff_wr", 64'(req_buff_wr), 64'd0);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        repeat (4) tick;
        $display("txn4 reset abort done");

        // Recovery after reset: pointer back at 0, so req1 write wins.
        req_lba[63:32] = 32'h99;
        push_exp(2'b10, 32'h99, 1'b0, 1'b1, 2, 0);
        req_wr[1] = 1'b1;
        serve(1, 2, 1'b0, 8'hA5);
        $display("txn5 write req1 after reset done");

`ifdef SD_ARB_TIMEOUT_EN
        req_lba = {32'h22, 32'h11};
        push_exp(2'b01, 32'h11, 1'b1, 1'b0, 0, 1);
        push_exp(2'b10, 32'h22, 1'b1, 1'b0, 2, 0);
        req_rd = 2'b11;
        n = 0;
        while (!sd_rd && n < 100) begin tick; n++; end
        n = 0;
        while (sd_rd && n < 100) begin tick; n++; end
        chk("timeout_len", 64'(n), 64'd16);
        req_rd[0] = 1'b0;
        serve(1, 2, 1'b0, 8'hA5);
        $display("txn6 timeout then req1 done");
`endif

        repeat (5) tick;
        chk("stray_outputs", 64'(stray), 64'd0);
        chk("pending_exp", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
